// File: rtl/map_pkg.sv
// Shared map constants for the maze tile server: grid geometry, coordinate widths,
// direction/state encodings and the constant wall and pellet ROM images.
package map_pkg;

    localparam int MAP_W_TILES = 40;
    localparam int MAP_H_TILES = 30;
    localparam int MAP_TILES   = MAP_W_TILES * MAP_H_TILES;

    localparam int X_W        = 10;
    localparam int Y_W        = 9;
    localparam int TILE_IDX_W = 11;
    localparam int LEFT_W     = 11;

    localparam logic [X_W-1:0] X_MAX = 10'd639;
    localparam logic [Y_W-1:0] Y_MAX = 9'd479;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Maze layout: solid border plus a pillar wherever both tile coordinates are 3 mod 4.
    function automatic logic is_wall_tile(input int tx, input int ty);
        logic border;
        logic pillar;
        border = (tx == 0) || (tx == MAP_W_TILES - 1) || (ty == 0) || (ty == MAP_H_TILES - 1);
        pillar = ((tx % 4) == 3) && ((ty % 4) == 3);
        return border || pillar;
    endfunction

    // Pellets sit on open tiles on a checkerboard (tx+ty even).
    function automatic logic is_pellet_tile(input int tx, input int ty);
        return !is_wall_tile(tx, ty) && (((tx + ty) % 2) == 0);
    endfunction

    function automatic logic [MAP_TILES-1:0] gen_wall_rom();
        logic [MAP_TILES-1:0] rom;
        rom = '0;
        for (int ty = 0; ty < MAP_H_TILES; ty++) begin
            for (int tx = 0; tx < MAP_W_TILES; tx++) begin
                rom[ty*MAP_W_TILES + tx] = is_wall_tile(tx, ty);
            end
        end
        return rom;
    endfunction

    function automatic logic [MAP_TILES-1:0] gen_pellet_rom();
        logic [MAP_TILES-1:0] rom;
        rom = '0;
        for (int ty = 0; ty < MAP_H_TILES; ty++) begin
            for (int tx = 0; tx < MAP_W_TILES; tx++) begin
                rom[ty*MAP_W_TILES + tx] = is_pellet_tile(tx, ty);
            end
        end
        return rom;
    endfunction

    function automatic logic [LEFT_W-1:0] count_ones(input logic [MAP_TILES-1:0] rom);
        logic [LEFT_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAP_TILES; i++) begin
            n = n + LEFT_W'(rom[i]);
        end
        return n;
    endfunction

    localparam logic [MAP_TILES-1:0] WALL_ROM     = gen_wall_rom();
    localparam logic [MAP_TILES-1:0] PELLET_ROM   = gen_pellet_rom();
    localparam logic [LEFT_W-1:0]    PELLET_COUNT = count_ones(PELLET_ROM);

    // Returns {in_range, row-major tile index}; the index is zero when out of range.
    function automatic logic [TILE_IDX_W:0] locate_tile(input logic [X_W-1:0] x,
                                                        input logic [Y_W-1:0] y,
                                                        input int shift);
        logic [X_W-1:0]        txf;
        logic [Y_W-1:0]        tyf;
        logic                  ok;
        logic [TILE_IDX_W-1:0] idx;
        txf = x >> shift;
        tyf = y >> shift;
        ok  = (x <= X_MAX) && (y <= Y_MAX) &&
              (txf < X_W'(MAP_W_TILES)) && (tyf < Y_W'(MAP_H_TILES));
        idx = ok ? (TILE_IDX_W'(tyf) * TILE_IDX_W'(MAP_W_TILES) + TILE_IDX_W'(txf)) : '0;
        return {ok, idx};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the requester after the last grant has highest priority;
// the pointer only moves when the caller reports the grant was actually taken.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_any_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin
        int k;
        k         = 0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr_q) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (!gnt_any_o && req_i[k]) begin
                gnt_any_o = 1'b1;
                gnt_o[k]  = 1'b1;
                gnt_idx_o = IDX_W'(k);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && gnt_any_o) begin
            ptr_d = (gnt_idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/map_query_server.sv
// Shared maze lookup: arbitrates tile queries from NUM_REQ requesters and answers
// each with the wall bit two cycles after acceptance. Optional pellet tracking is
// built only when MAP_PELLET_EN is defined.
module map_query_server
    import map_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int TILE_SHIFT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*X_W-1:0] req_x,
    input  logic [NUM_REQ*Y_W-1:0] req_y,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic                   rsp_wall,
`ifdef MAP_PELLET_EN
    input  logic                   eat_valid,
    input  logic [X_W-1:0]         eat_x,
    input  logic [Y_W-1:0]         eat_y,
    output logic                   rsp_pellet,
    output logic [LEFT_W-1:0]      pellets_left,
`endif
    output logic [1:0]             dbg_state
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [MAP_TILES-1:0] WALL_BITS = WALL_ROM;

    state_t             state_q, state_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic               wall_q, wall_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic               accept;

    logic                  q_ok;
    logic [TILE_IDX_W-1:0] q_idx;
    logic [NUM_REQ-1:0]    rsp_onehot;

    // Handshake: a request transfers in the cycle where req_valid[i] and req_ready[i]
    // are both high; the requester holds x/y stable until then. req_ready is a
    // one-cycle one-hot pulse issued only in IDLE, and rsp_valid is a one-cycle
    // one-hot pulse two cycles later with rsp_wall (and rsp_pellet) alongside.
    assign accept    = (state_q == ST_IDLE) && rst_n && gnt_any;
    assign req_ready = accept ? gnt : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req_valid),
        .advance_i (accept),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (gnt_any)
    );

    assign {q_ok, q_idx} = locate_tile(x_q, y_q, TILE_SHIFT);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        gidx_d  = gidx_q;
        wall_d  = wall_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_READ;
                    x_d     = req_x[int'(gnt_idx)*X_W +: X_W];
                    y_d     = req_y[int'(gnt_idx)*Y_W +: Y_W];
                    gidx_d  = gnt_idx;
                end
            end
            ST_READ: begin
                state_d = ST_RESP;
                // Off-map coordinates read as wall and never touch the ROM.
                wall_d  = !q_ok || WALL_BITS[q_idx];
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            gidx_q  <= '0;
            wall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            gidx_q  <= gidx_d;
            wall_q  <= wall_d;
        end
    end

    always_comb begin
        rsp_onehot = '0;
        if (state_q == ST_RESP) begin
            rsp_onehot[gidx_q] = 1'b1;
        end
    end

    assign rsp_valid = rsp_onehot;
    assign rsp_wall  = (state_q == ST_RESP) && wall_q;
    assign dbg_state = state_q;

`ifdef MAP_PELLET_EN
    localparam logic [MAP_TILES-1:0] PELLET_BITS = PELLET_ROM;

    logic [MAP_TILES-1:0]  eaten_q, eaten_d;
    logic [LEFT_W-1:0]     left_q, left_d;
    logic                  pel_q, pel_d;
    logic                  e_ok;
    logic [TILE_IDX_W-1:0] e_idx;

    assign {e_ok, e_idx} = locate_tile(eat_x, eat_y, TILE_SHIFT);

    // The query reads eaten_q, so a same-cycle eat of that tile is not yet visible.
    always_comb begin
        eaten_d = eaten_q;
        left_d  = left_q;
        pel_d   = pel_q;
        if (eat_valid && e_ok) begin
            eaten_d[e_idx] = 1'b1;
            if (PELLET_BITS[e_idx] && !eaten_q[e_idx] && (left_q != '0)) begin
                left_d = left_q - 1'b1;
            end
        end
        if (state_q == ST_READ) begin
            pel_d = q_ok && PELLET_BITS[q_idx] && !eaten_q[q_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            eaten_q <= '0;
            left_q  <= PELLET_COUNT;
            pel_q   <= 1'b0;
        end else begin
            eaten_q <= eaten_d;
            left_q  <= left_d;
            pel_q   <= pel_d;
        end
    end

    assign rsp_pellet   = (state_q == ST_RESP) && pel_q;
    assign pellets_left = left_q;
`endif

endmodule

// File: tb/tb_map_query_server.sv
// Directed bench for map_query_server: reset, single lookups, range edges, fairness,
// mid-operation reset and (with MAP_PELLET_EN) pellet bookkeeping.
module tb_map_query_server;

    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR*10-1:0] req_x;
    logic [NR*9-1:0] req_y;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   rsp_valid;
    logic            rsp_wall;
    logic [1:0]      dbg_state;
`ifdef MAP_PELLET_EN
    logic            eat_valid;
    logic [9:0]      eat_x;
    logic [8:0]      eat_y;
    logic            rsp_pellet;
    logic [10:0]     pellets_left;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Expected response entry: {one-hot requester, wall, pellet}.
    logic [5:0] exp_q[$];

    map_query_server #(
        .NUM_REQ    (NR),
        .TILE_SHIFT (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_wall     (rsp_wall),
`ifdef MAP_PELLET_EN
        .eat_valid    (eat_valid),
        .eat_x        (eat_x),
        .eat_y        (eat_y),
        .rsp_pellet   (rsp_pellet),
        .pellets_left (pellets_left),
`endif
        .dbg_state    (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every response pulse is matched against the oldest expected entry.
    always @(negedge clk) begin
        logic [5:0] e;
        if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("rsp_who", 32'(rsp_valid), 32'(e[5:2]));
                check("rsp_wall", 32'(rsp_wall), 32'(e[1]));
`ifdef MAP_PELLET_EN
                check("rsp_pellet", 32'(rsp_pellet), 32'(e[0]));
`endif
            end
        end
    end

    task automatic set_coord(input int r, input int x, input int y);
        req_x[r*10 +: 10] = 10'(x);
        req_y[r*9 +: 9]   = 9'(y);
    endtask

    // Driver: one request, checks acceptance and the exact two-cycle response timing.
    task automatic send(input int r, input int x, input int y, input logic w, input logic p);
        logic        seen;
        logic [3:0]  oh;
        oh = 4'(1 << r);
        @(negedge clk);
        set_coord(r, x, y);
        req_valid[r] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready[r]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept_seen", 32'(seen), 32'(1));
        if (!seen) begin
            req_valid[r] = 1'b0;
            return;
        end
        exp_q.push_back({oh, w, p});
        @(negedge clk);
        req_valid[r] = 1'b0;
        check("rsp_t1_quiet", 32'(rsp_valid), 32'(0));
        @(negedge clk);
        check("rsp_t2_pulse", 32'(rsp_valid), 32'(oh));
        @(negedge clk);
        check("rsp_t3_quiet", 32'(rsp_valid), 32'(0));
    endtask

`ifdef MAP_PELLET_EN
    task automatic eat_tile(input int x, input int y);
        @(negedge clk);
        eat_valid = 1'b1;
        eat_x     = 10'(x);
        eat_y     = 9'(y);
        @(negedge clk);
        eat_valid = 1'b0;
    endtask
`endif

    initial begin
        logic [3:0] fw;
        logic [3:0] fp;
        int         ngr;
        int         last;
        logic       seen;

        rst_n     = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
`ifdef MAP_PELLET_EN
        eat_valid = 1'b0;
        eat_x     = '0;
        eat_y     = '0;
`endif
        repeat (3) @(negedge clk);
        req_valid = 4'hF;
        #1;
        check("rst_ready", 32'(req_ready), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_wall", 32'(rsp_wall), 32'(0));
        check("rst_state", 32'(dbg_state), 32'(0));
`ifdef MAP_PELLET_EN
        check("rst_pellets_left", 32'(pellets_left), 32'(469));
`endif

        // Fairness: all four held high from reset.
        @(negedge clk);
        rst_n = 1'b1;
        set_coord(0, 0, 0);
        set_coord(1, 24, 24);
        set_coord(2, 56, 56);
        set_coord(3, 623, 24);
        fw = 4'b0101;
        fp = 4'b0010;
        ngr  = 0;
        last = 0;
        for (int k = 0; k < 40 && ngr < 5; k++) begin
            #1;
            if (req_ready != '0) begin
                check("fair_grant", 32'(req_ready), 32'(1 << (ngr % 4)));
                if (ngr > 0) check("fair_spacing", 32'(cyc - last), 32'(3));
                last = cyc;
                exp_q.push_back({4'(1 << (ngr % 4)), fw[ngr % 4], fp[ngr % 4]});
                ngr++;
            end
            @(negedge clk);
        end
        req_valid = '0;
        check("fair_count", 32'(ngr), 32'(5));
        repeat (3) @(negedge clk);

        // Single lookups across open, wall, pillar and range edges.
        send(0, 0, 0, 1'b1, 1'b0);
        send(1, 24, 24, 1'b0, 1'b1);
        send(2, 700, 100, 1'b1, 1'b0);
        send(3, 100, 500, 1'b1, 1'b0);
        send(0, 639, 479, 1'b1, 1'b0);
        send(1, 640, 24, 1'b1, 1'b0);
        send(2, 623, 24, 1'b0, 1'b0);
        send(3, 56, 56, 1'b1, 1'b0);
        send(2, 56, 24, 1'b0, 1'b1);
        send(0, 40, 24, 1'b0, 1'b0);

`ifdef MAP_PELLET_EN
        eat_tile(24, 24);
        check("pellets_eat1", 32'(pellets_left), 32'(468));
        eat_tile(24, 24);
        check("pellets_eat2", 32'(pellets_left), 32'(468));
        eat_tile(40, 24);
        check("pellets_eat_empty", 32'(pellets_left), 32'(468));
        send(1, 24, 24, 1'b0, 1'b0);
`endif

        // Mid-operation reset drops the in-flight response and rewinds the pointer.
        @(negedge clk);
        set_coord(1, 24, 24);
        req_valid = 4'b0010;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready[1]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("midrst_accept", 32'(seen), 32'(1));
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b0;
        @(negedge clk);
        check("midrst_no_rsp", 32'(rsp_valid), 32'(0));
        check("midrst_state", 32'(dbg_state), 32'(0));
        rst_n = 1'b1;
        set_coord(0, 0, 0);
        set_coord(2, 56, 56);
        set_coord(3, 623, 24);
        req_valid = 4'hF;
        #1;
        check("midrst_next_grant", 32'(req_ready), 32'(1));
        if (req_ready == 4'b0001) exp_q.push_back({4'b0001, 1'b1, 1'b0});
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);
`ifdef MAP_PELLET_EN
        check("midrst_pellets_left", 32'(pellets_left), 32'(469));
        send(1, 24, 24, 1'b0, 1'b1);
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/map_query_server.md
MAP_QUERY_SERVER -- requirements
Module: map_query_server

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (ghosts plus player), range 1..8.
REQ-002 Parameter TILE_SHIFT, default 4, log2 of tile edge in pixels (16-px tiles).
REQ-003 clk  input  1  sole clock; all logic is posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester lookup request.
REQ-006 req_x  input  NUM_REQ*10  per-requester pixel X, 0..639 valid.
REQ-007 req_y  input  NUM_REQ*9  per-requester pixel Y, 0..479 valid.
REQ-008 req_ready  output  NUM_REQ  one-hot accept pulse.
REQ-009 rsp_valid  output  NUM_REQ  one-hot response pulse.
REQ-010 rsp_wall  output  1  wall flag, meaningful only while any rsp_valid bit is high.

Function
REQ-011 Tile index is tx = x>>TILE_SHIFT and ty = y>>TILE_SHIFT on a 40x30 grid; wall bitmap is a constant ROM of 1200 bits, row-major, index ty*40+tx.
REQ-012 FSM states: IDLE, READ, RESP; IDLE->READ when any req_valid is set; READ->RESP unconditionally; RESP->IDLE unconditionally.
REQ-013 In IDLE with any req_valid set, the round-robin arbiter grants exactly one requester, asserts req_ready for that requester for that cycle only, and latches its x/y.
REQ-014 Round-robin priority starts at the requester after the last granted one; after reset, requester 0 has highest priority.
REQ-015 A transfer occurs only when req_valid and req_ready are both high; a request is held by the requester until accepted.
REQ-016 For an accept in cycle T, rsp_valid[g] is high in cycle T+2 for one cycle only and rsp_wall carries the ROM bit; maximum throughput is one request per 3 cycles.
REQ-017 Coordinates with x>639 or y>479 return rsp_wall=1 without ROM access, with the same latency.
REQ-018 req_valid deasserted after acceptance does not affect the pending response.
REQ-019 No new grant is made in READ or RESP; req_ready is 0 there.

Reset
REQ-020 With rst_n low at a posedge, state goes to IDLE, req_ready=0, rsp_valid=0, rsp_wall=0, and the arbiter pointer goes to 0.
REQ-021 Reset asserted during READ or RESP discards the in-flight response; no rsp_valid is produced for it.

Configuration
REQ-022 Macro MAP_PELLET_EN enables pellet tracking. Without the macro, none of the pellet ports or logic exist.
REQ-023 With MAP_PELLET_EN, the block adds these ports: eat_valid in 1, eat_x in 10, eat_y in 9, rsp_pellet out 1, pellets_left out 11.
REQ-024 Pellet state is a 1200-bit eaten map, cleared on reset.
REQ-025 rsp_pellet = pellet ROM bit AND NOT eaten bit, sampled in READ.
REQ-026 eat_valid sets the eaten bit of its tile at the clock edge; the eat takes effect in the cycle it is sampled.
REQ-027 pellets_left resets to the ROM pellet count and decrements only when an uneaten pellet tile is eaten; it saturates at 0.
REQ-028 An eat and a READ of the same tile in the same cycle return the pre-eat value.

Structure
REQ-029 Shared package map_pkg holds MAP_W_TILES=40, MAP_H_TILES=30, coordinate widths, the direction typedef (00 up, 01 right, 10 down, 11 left), and the wall/pellet ROM constants.
REQ-030 The round-robin arbiter is a sub-module named rr_arbiter; the ROM is inferred inside map_query_server.

Verification
REQ-031 Single request: req 0 at (0,0), a border wall, accepted at T -> rsp_valid=0001 at T+2, rsp_wall=1.
REQ-032 Open corridor: req 1 at (24,24), tile (1,1) open -> rsp_valid=0010, rsp_wall=0, 2 cycles after accept.
REQ-033 Fairness: all 4 req_valid held high -> grants 0,1,2,3,0 at 3-cycle spacing, with no duplicate or starvation.
REQ-034 Out of range: req (700,100) -> rsp_wall=1; req (100,500) -> rsp_wall=1.
REQ-035 Mid-op reset: accept at T, rst_n low at T+1 -> no rsp_valid at T+2; the next grant goes to requester 0.
REQ-036 MAP_PELLET_EN: eat the pellet tile (1,1) twice -> pellets_left decrements once; a later query of (1,1) -> rsp_pellet=0.
